// File: rtl/icu_program_sequencer.sv
// Program counter and return-address stack feeding an MC14500B-style ICU from a registered ROM.
// JMP, call (NOPF) and RTN resolve in the execute phase, so the ROM is never idle.
module icu_program_sequencer #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                           clk_in,
    input  logic                           rst,
    output logic [ADDR_WIDTH-1:0]          prog_addr,
    input  logic [ADDR_WIDTH+3:0]          prog_data,
    output logic [3:0]                     icu_inst,
    input  logic                           icu_state,
    input  logic                           icu_skp,
    output logic [ADDR_WIDTH-1:0]          io_addr,
    output logic [ADDR_WIDTH-1:0]          pc,
    output logic [$clog2(STACK_DEPTH):0]   sp,
    output logic                           stack_err
);

    localparam int unsigned PtrW = $clog2(STACK_DEPTH);
    localparam int unsigned SpW  = PtrW + 1;

    localparam logic [3:0]            OpJmp   = 4'b1100;
    localparam logic [3:0]            OpCall  = 4'b1111;
    localparam logic [3:0]            OpRtn   = 4'b1101;
    localparam logic [SpW-1:0]        SpFull  = SpW'(STACK_DEPTH);
    localparam logic [SpW-1:0]        SpOne   = SpW'(1);
    localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] io_addr_q;
    logic [3:0]            op_q;
    logic [SpW-1:0]        sp_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [SpW-1:0]        sp_dec;
    logic                  push_req;
    logic                  pop_req;
    logic                  err_req;

    assign pc_inc = pc_q + AddrOne;
    assign sp_dec = sp_q - SpOne;

    always_comb begin
        next_pc  = pc_inc;
        push_req = 1'b0;
        pop_req  = 1'b0;
        err_req  = 1'b0;
        // A skipped instruction never branches or touches the stack.
        if (!icu_skp) begin
            case (op_q)
                OpJmp: begin
                    next_pc = io_addr_q;
                end
                OpCall: begin
                    next_pc = io_addr_q;
                    if (sp_q == SpFull) begin
                        err_req = 1'b1;
                    end else begin
                        push_req = 1'b1;
                    end
                end
                OpRtn: begin
                    if (sp_q == '0) begin
                        err_req = 1'b1;
                    end else begin
                        pop_req = 1'b1;
                        next_pc = stack_q[sp_dec[PtrW-1:0]];
                    end
                end
                default: begin
                    next_pc = pc_inc;
                end
            endcase
        end
    end

    // Execute presents next_pc early so the ROM word is ready for the following fetch.
    always_comb begin
        if (rst) begin
            prog_addr = '0;
        end else if (icu_state) begin
            prog_addr = next_pc;
        end else begin
            prog_addr = pc_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            pc_q      <= '0;
            io_addr_q <= '0;
            op_q      <= '0;
            sp_q      <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (!icu_state) begin
            op_q      <= prog_data[ADDR_WIDTH+3:ADDR_WIDTH];
            io_addr_q <= prog_data[ADDR_WIDTH-1:0];
        end else begin
            pc_q <= next_pc;
            if (push_req) begin
                stack_q[sp_q[PtrW-1:0]] <= pc_q;
                sp_q                    <= sp_q + SpOne;
            end else if (pop_req) begin
                sp_q <= sp_dec;
            end
            if (err_req) begin
                err_q <= 1'b1;
            end
        end
    end

    assign icu_inst  = prog_data[ADDR_WIDTH+3:ADDR_WIDTH];
    assign io_addr   = io_addr_q;
    assign pc        = pc_q;
    assign sp        = sp_q;
    assign stack_err = err_q;

endmodule

// File: doc/icu_program_sequencer.md
Name: icu_program_sequencer

Overview:
- Program counter and subroutine-stack controller that feeds the MC14500B-style ICU core from a synchronous program ROM.
- Each ROM word holds a 4-bit opcode and an ADDR_WIDTH-bit operand. The opcode goes to the ICU's I input. The operand serves as the I/O bit address, or as the jump/call target.
- The block tracks ICU phase through the ICU's state_out and SKP signals. It resolves JMP, call (NOPF) and RTN itself, so there is no fetch bubble.

Parameters:
ADDR_WIDTH, 8, program counter / operand width; program space 2^ADDR_WIDTH words
STACK_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
clk_in  in  1  system clock, same clock as the ICU
rst  in  1  synchronous reset, active-high
prog_addr  out  ADDR_WIDTH  ROM read address (ROM registers it: data valid 1 clk later)
prog_data  in  4+ADDR_WIDTH  ROM word; [ADDR_WIDTH+3:ADDR_WIDTH]=opcode, [ADDR_WIDTH-1:0]=operand
icu_inst  out  4  opcode to ICU I input
icu_state  in  1  ICU state_out (0=FETCH, 1=DECODE_EXECUTE)
icu_skp  in  1  ICU SKP
io_addr  out  ADDR_WIDTH  operand of the instruction currently in ICU execute
pc  out  ADDR_WIDTH  address of the current instruction (debug)
sp  out  $clog2(STACK_DEPTH)+1  stack occupancy, 0..STACK_DEPTH
stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset:
  - rst=1 at a clk_in edge: pc=0, sp=0, stack entries=0, stack_err=0, op_q=0, io_addr=0.
  - prog_addr=0 while rst=1.
  - Reset mid-program discards any pending jump or stack operation.
- Phase lock: no internal phase counter. icu_state selects the phase; one ICU instruction takes 2 clk_in cycles.
- FETCH (icu_state=0):
  - icu_inst = prog_data opcode, combinational; the ICU latches it at the clock edge.
  - prog_addr = pc.
  - At the edge: op_q <= opcode and io_addr <= operand. These are held through execute.
- EXECUTE (icu_state=1): prog_addr = next_pc (combinational). At the edge: pc <= next_pc and the stack is updated.
- next_pc priority:
  1. icu_skp=1: instruction is being skipped. next_pc = pc+1; no stack action, whatever op_q is.
  2. op_q=4'b1100 (JMP): next_pc = io_addr.
  3. op_q=4'b1111 (NOPF = call): push pc, then next_pc = io_addr.
  4. op_q=4'b1101 (RTN): pop, next_pc = popped value. The pushed value is the call's own address. The ICU skips the re-fetched call word after RTN, so execution resumes at call+1.
  5. Otherwise next_pc = pc+1.
- Arithmetic: pc+1 is modulo 2^ADDR_WIDTH (wraps max to 0).
- Stack boundaries:
  - Push with sp=STACK_DEPTH: push dropped, sp unchanged, stack_err<=1, jump still taken.
  - Pop with sp=0: next_pc = pc+1, sp stays 0, stack_err<=1.
- stack_err clears only on rst.
- icu_inst outside FETCH passes prog_data through unchanged; the ICU ignores it.

Test Plan:
- Reset/linear: rst 2 clks, ROM 0..3 = LD/AND/OR/STO, operands 5,6,7,8 -> prog_addr 0,1,1,2,2,3; icu_inst sequence 1,3,5,8; io_addr 5,6,7,8 in execute.
- Jump: ROM[3]=JMP 0x40 -> during execute of addr 3, prog_addr=0x40; next fetched word is ROM[0x40]; pc=0x40; sp unchanged.
- Skipped jump: SKZ at 0x10 with RR=0, JMP 0x80 at 0x11 -> icu_skp=1 in execute of 0x11; pc=0x12; no jump.
- Call/return: NOPF 0x20 at 0x05, RTN at 0x21 -> sp 0->1->0; after RTN prog_addr=0x05; ICU skips it; next executed pc=0x06; stack_err=0.
- Overflow/underflow with STACK_DEPTH=4: 5 nested calls -> sp=4, stack_err=1, 5th target still reached. RTN with sp=0 -> pc+1, stack_err stays 1 until rst.
- Wrap/reset: pc=0xFF non-branch -> next pc=0x00. Assert rst during execute of a call -> sp=0, pc=0, stack_err=0 next clk.
